if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/if_id_entry.sv | 23 ++
 rtl/if_id_buffer.sv | 113 +++++++++++
 tb/tb_if_id_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared instruction-field geometry, buffer state encoding and entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_W       = 32;
    localparam int OPCODE_W   = 6;
    localparam int REG_W      = 5;
    localparam int SHAMT_W    = 5;
    localparam int FUNCT_W    = 6;
    localparam int IMM_W      = 16;
    localparam int TARGET_W   = 26;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_LSB = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_entry.sv
// One {instr, pc} holding register with load enable and synchronous clear.
// Latency: loaded value visible one cycle after load.
// Backpressure: none; retains value whenever load is low.
module if_id_entry
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   clr_n,
    input  logic   load,
    input  entry_t d,
    output entry_t q
);

    // Clear dominates load; otherwise capture on load, else hold.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode, splitting the head instruction into fields.
// Latency: one cycle input-to-output from empty; fields are pure slices of the head register.
// Backpressure: in_ready depends only on registered state (low when both entries held); no out_ready->in_ready path.
module if_id_buffer
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [FUNCT_W-1:0]  funct,
    output logic [IMM_W-1:0]    imm,
    output logic [TARGET_W-1:0] target,
    output logic [PC_W-1:0]     pc_plus4
);

    buf_state_t state, state_nxt;
    entry_t     head_q, skid_q, in_entry, head_d;
    logic       head_load, skid_load, head_from_skid;
    logic       in_fire, out_fire;

    assign in_entry  = '{instr: in_instr, pc: in_pc};
    assign in_ready  = (state == ST_EMPTY) || (state == ST_ONE);
    assign out_valid = (state == ST_ONE)   || (state == ST_FULL);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign head_d    = head_from_skid ? skid_q : in_entry;

    // State register; reset wins over flush and any transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and register load steering; flush drops to EMPTY without loading anything.
    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_ONE;
                        head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_nxt      = ST_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    if_id_entry u_head (
        .clk   (clk),
        .clr_n (rst_n),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    if_id_entry u_skid (
        .clk   (clk),
        .clr_n (rst_n),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    // Decode fields come straight from the head register, so they stay put while stalled or empty.
    assign opcode   = head_q.instr[OPCODE_LSB +: OPCODE_W];
    assign rs       = head_q.instr[RS_LSB     +: REG_W];
    assign rt       = head_q.instr[RT_LSB     +: REG_W];
    assign rd       = head_q.instr[RD_LSB     +: REG_W];
    assign shamt    = head_q.instr[SHAMT_LSB  +: SHAMT_W];
    assign funct    = head_q.instr[FUNCT_LSB  +: FUNCT_W];
    assign imm      = head_q.instr[IMM_LSB    +: IMM_W];
    assign target   = head_q.instr[TARGET_LSB +: TARGET_W];
    assign pc_plus4 = pc_next(head_q.pc);

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed and randomized-stream bench for if_id_buffer.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: drives out_ready low/high/random to exercise stalls and the skid entry.
module tb_if_id_buffer;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;

    int total = 0;
    int bad   = 0;

    entry_t      q[$];
    entry_t      e;
    int          sent, rcvd, cnt;
    logic        hold;
    logic [31:0] snap_instr, snap_pc4;

    always #5 clk = ~clk;

    if_id_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target), .pc_plus4(pc_plus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = p;
    endtask

    function automatic logic [31:0] cur_instr();
        return {opcode, rs, rt, rd, shamt, funct};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_instr",     cur_instr(),    32'd0);
        chk("rst_imm",       32'(imm),       32'd0);
        chk("rst_pc_plus4",  pc_plus4,       32'h0000_0004);

        // addi $9,$9,-1 at 0x00400000
        out_ready = 1'b1;
        put(32'h2129_FFFF, 32'h0040_0000);
        step();
        in_valid = 1'b0;
        chk("first_out_valid", 32'(out_valid), 32'd1);
        chk("first_opcode",    32'(opcode),    32'h08);
        chk("first_rs",        32'(rs),        32'd9);
        chk("first_rt",        32'(rt),        32'd9);
        chk("first_imm",       32'(imm),       32'hFFFF);
        chk("first_pc_plus4",  pc_plus4,       32'h0040_0004);
        step();
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("empty_keeps_op",  32'(opcode),    32'h08);
        chk("empty_keeps_pc4", pc_plus4,       32'h0040_0004);

        // Back-to-back A,B,C with decode stalled
        out_ready = 1'b0;
        put(32'h0085_1020, 32'h0000_0100);
        step();
        chk("a_in_ready",  32'(in_ready),  32'd1);
        chk("a_out_valid", 32'(out_valid), 32'd1);
        chk("a_rs",        32'(rs),        32'd4);
        chk("a_rt",        32'(rt),        32'd5);
        chk("a_rd",        32'(rd),        32'd2);
        chk("a_funct",     32'(funct),     32'h20);
        put(32'h8D09_0004, 32'h0000_0200);
        step();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_pc4", pc_plus4,      32'h0000_0104);
        put(32'h0800_0010, 32'h0000_0300);
        step();
        chk("c_held_in_ready", 32'(in_ready), 32'd0);
        chk("stall_head_pc4",  pc_plus4,      32'h0000_0104);
        chk("stall_head_ins",  cur_instr(),   32'h0085_1020);
        out_ready = 1'b1;
        step();
        chk("b_pc_plus4", pc_plus4,      32'h0000_0204);
        chk("b_opcode",   32'(opcode),   32'h23);
        chk("b_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("c_pc_plus4",  pc_plus4,       32'h0000_0304);
        chk("c_target",    32'(target),    32'h10);
        chk("c_out_valid", 32'(out_valid), 32'd1);
        step();
        chk("abc_drained", 32'(out_valid), 32'd0);

        // Flush in FULL with a simultaneous input
        out_ready = 1'b0;
        put(32'h1111_1111, 32'h0000_0400);
        step();
        put(32'h2222_2222, 32'h0000_0500);
        step();
        chk("d_e_full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        put(32'h3333_3333, 32'h0000_0600);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready",  32'(in_ready),  32'd1);
        chk("flush_keeps_pc4", pc_plus4,       32'h0000_0404);
        step();
        chk("flush_no_ghost", 32'(out_valid), 32'd0);

        // Flush in ONE with an acceptable input: input is discarded
        put(32'h4444_4444, 32'h0000_0900);
        step();
        flush = 1'b1;
        put(32'h5555_5555, 32'h0000_0A00);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("flush1_no_ghost", 32'(out_valid), 32'd0);
        chk("flush1_keeps",    pc_plus4,       32'h0000_0904);

        // pc wraparound
        put(32'h0000_0000, 32'hFFFF_FFFC);
        step();
        in_valid = 1'b0;
        chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        out_ready = 1'b1;
        step();
        chk("wrap_drained", 32'(out_valid), 32'd0);

        // Reset while FULL and decode ready
        out_ready = 1'b0;
        put(32'hDEAD_BEEF, 32'h0000_0700);
        step();
        put(32'hCAFE_F00D, 32'h0000_0800);
        step();
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1; out_ready = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_instr",     cur_instr(),    32'd0);
        chk("mid_rst_target",    32'(target),    32'd0);
        chk("mid_rst_pc_plus4",  pc_plus4,       32'h0000_0004);
        step();
        chk("mid_rst_stays_empty", 32'(out_valid), 32'd0);

        // Random streaming of 1000 words against a queue model
        sent = 0; rcvd = 0; cnt = 0;
        for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_instr  = $urandom;
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            hold       = out_valid && !out_ready;
            snap_instr = cur_instr();
            snap_pc4   = pc_plus4;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rand_instr", cur_instr(), e.instr);
                    chk("rand_imm",   32'(imm),    32'(e.instr[15:0]));
                    chk("rand_pc4",   pc_plus4,    e.pc + 32'd4);
                    rcvd++;
                    cnt--;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{instr: in_instr, pc: in_pc});
                sent++;
                cnt++;
            end
            step();
            chk("rand_out_valid", 32'(out_valid), 32'(cnt > 0));
            chk("rand_in_ready",  32'(in_ready),  32'(cnt < 2));
            if (hold) begin
                chk("rand_stable_instr", cur_instr(), snap_instr);
                chk("rand_stable_pc4",   pc_plus4,    snap_pc4);
            end
        end
        in_valid = 1'b0;
        chk("rand_words_out", 32'(rcvd), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
